bus_arbiter_mux: RTL

Parametrised, registered successor to the CPU's combinational bus multiplexer. It chooses one source per cycle from external data-in, the ALU result and NREG register outputs. Fixed priority applies to data-in and ALU; register requests are served round-robin. The selected word goes into an output register with a valid/ready handshake. It sits between the register file/ALU and the shared datapath bus, and lets bus consumers stall the bus without losing data.

---
 rtl/bus_arbiter_mux.sv | 68 ++++++
 1 files changed

// File: rtl/bus_arbiter_mux.sv
// bus_arbiter_mux: registered bus mux with din > alu > round-robin register priority behind a valid/ready output stage
module bus_arbiter_mux #(
  parameter int WIDTH = 16,
  parameter int NREG = 8,
  parameter int SRCW = $clog2(NREG + 2)
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [WIDTH-1:0]      din,
  input  logic                  din_en,
  input  logic [WIDTH-1:0]      aluout,
  input  logic                  gout,
  input  logic [NREG*WIDTH-1:0] regs,
  input  logic [NREG-1:0]       r_req,
  input  logic                  bus_ready,
  input  logic                  clear_err,
  output logic [WIDTH-1:0]      buswires,
  output logic                  bus_valid,
  output logic [SRCW-1:0]       bus_src,
  output logic                  din_ack,
  output logic                  alu_ack,
  output logic [NREG-1:0]       r_grant,
  output logic                  conflict
);
  localparam int PW = $clog2(NREG);
  logic [PW-1:0] rr_ptr, rr_idx;
  logic [WIDTH-1:0] rr_data;
  logic rr_hit, load_en, any_req;
  function automatic int wrap(input int k);
    return k >= NREG ? k - NREG : k;
  endfunction
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = '0;
    rr_data = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (r_req[wrap(int'(rr_ptr) + i)]) begin
        rr_hit = 1'b1;
        rr_idx = PW'(wrap(int'(rr_ptr) + i));
        rr_data = regs[wrap(int'(rr_ptr) + i) * WIDTH +: WIDTH];
      end
    end
  end
  assign load_en = resetn && (!bus_valid || bus_ready);
  assign any_req = din_en || gout || rr_hit;
  assign din_ack = load_en && din_en;
  assign alu_ack = load_en && !din_en && gout;
  assign r_grant = (load_en && !din_en && !gout && rr_hit) ? NREG'(1) << rr_idx : '0;
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      buswires <= '0;
      bus_valid <= 1'b0;
      bus_src <= '0;
      rr_ptr <= '0;
      conflict <= 1'b0;
    end else begin
      conflict <= (din_en && gout) || (conflict && !clear_err);
      if (load_en) begin
        bus_valid <= any_req;
        if (any_req) begin
          buswires <= din_en ? din : gout ? aluout : rr_data;
          bus_src <= din_en ? SRCW'(NREG + 1) : gout ? SRCW'(NREG) : SRCW'(rr_idx);
        end
        if (!din_en && !gout && rr_hit) rr_ptr <= rr_idx == PW'(NREG - 1) ? '0 : rr_idx + 1'b1;
      end
    end
  end
endmodule
